// File: rtl/multi_edge_timestamper.sv
// Multi-channel edge timestamper: per-channel glitch filter, programmable edge
// polarity selection, merged {timestamp, edges, polarity} entries pushed into a
// first-word-fall-through FIFO with sticky overflow and a saturating drop counter.
module multi_edge_timestamper #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FILT_LEN   = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [N_CH-1:0]                 i_din,
  input  logic [2*N_CH-1:0]               i_mode,
  output logic                            o_ev_valid,
  input  logic                            i_ev_ready,
  output logic [TS_W-1:0]                 o_ev_ts,
  output logic [N_CH-1:0]                 o_ev_edges,
  output logic [N_CH-1:0]                 o_ev_pol,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
  output logic                            o_overflow,
  input  logic                            i_overflow_clr,
  output logic [15:0]                     o_drop_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = TS_W + 2 * N_CH;
  // Run count at which the next differing sample confirms the change.
  localparam logic [3:0]  FiltLast = 4'(FILT_LEN - 1);

  logic [TS_W-1:0] r_ts_cnt;
  logic            r_armed;
  logic [N_CH-1:0] r_filt;
  logic [3:0]      r_run [N_CH];

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic [N_CH-1:0] w_filt_d;
  logic [3:0]      w_run_d [N_CH];
  logic [N_CH-1:0] w_edges;
  logic [N_CH-1:0] w_pol;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic [EW-1:0]   w_head;

  // Filter next state and edge detection; the arm cycle loads din without edges.
  always_comb begin
    w_filt_d = r_filt;
    w_edges  = '0;
    w_pol    = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      w_run_d[c] = r_run[c];
      if (!r_armed) begin
        w_filt_d[c] = i_din[c];
        w_run_d[c]  = '0;
      end else if (i_din[c] != r_filt[c]) begin
        if (r_run[c] == FiltLast) begin
          w_filt_d[c] = i_din[c];
          w_run_d[c]  = '0;
          if (i_din[c] && i_mode[2*c]) begin
            w_edges[c] = 1'b1;
            w_pol[c]   = 1'b1;
          end else if (!i_din[c] && i_mode[2*c+1]) begin
            w_edges[c] = 1'b1;
          end
        end else begin
          w_run_d[c] = r_run[c] + 4'd1;
        end
      end else begin
        w_run_d[c] = '0;
      end
    end
  end

  assign o_ev_valid = (r_level != '0);
  assign w_pop      = o_ev_valid & i_ev_ready;
  assign w_push     = (|w_edges) & ~i_reset;
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr       = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  assign w_head       = r_mem[r_rptr];
  assign o_ev_ts      = o_ev_valid ? w_head[EW-1 -: TS_W] : '0;
  assign o_ev_edges   = o_ev_valid ? w_head[2*N_CH-1 -: N_CH] : '0;
  assign o_ev_pol     = o_ev_valid ? w_head[N_CH-1:0] : '0;
  assign o_fifo_level = r_level;
  assign o_overflow   = r_overflow;
  assign o_drop_cnt   = r_drop_cnt;

  // Free-running timestamp and per-channel filter state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ts_cnt <= '0;
      r_armed  <= 1'b0;
      r_filt   <= '0;
      for (int c = 0; c < int'(N_CH); c++) r_run[c] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      r_armed  <= 1'b1;
      r_filt   <= w_filt_d;
      for (int c = 0; c < int'(N_CH); c++) r_run[c] <= w_run_d[c];
    end
  end

  // Entry storage; entries carry the timestamp sampled before the confirming edge.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= {r_ts_cnt, w_edges, w_pol};
  end

  // FIFO pointers, occupancy and overflow bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // A drop wins over a simultaneous clear so the new loss stays visible.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (i_overflow_clr)              r_drop_cnt <= 16'd1;
        else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/multi_edge_timestamper.md
MULTI_EDGE_TIMESTAMPER -- requirements
Module: multi_edge_timestamper

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter TS_W, default 32: timestamp counter width in bits (8..64).
REQ-003 Parameter FIFO_DEPTH, default 16: event FIFO depth in entries (power of two, 2..256).
REQ-004 Parameter FILT_LEN, default 2: consecutive differing samples required to accept a level change (1..15).
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 din  in  N_CH  asynchronous-origin channel levels; already synchronised upstream.
REQ-008 mode  in  2*N_CH  per-channel select, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 ev_valid  out  1  event entry available at the FIFO head.
REQ-010 ev_ready  in  1  consumer accepts the head entry when ev_valid and ev_ready are high.
REQ-011 ev_ts  out  TS_W  timestamp of the head entry.
REQ-012 ev_edges  out  N_CH  channels with a reported edge in the head entry.
REQ-013 ev_pol  out  N_CH  per-channel polarity of the head entry: 1 rising, 0 falling; 0 where ev_edges is 0.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of stored entries.
REQ-015 overflow  out  1  sticky flag: at least one event was dropped.
REQ-016 overflow_clr  in  1  single-cycle pulse that clears overflow and drop_cnt.
REQ-017 drop_cnt  out  16  saturating count of dropped events.

Function
REQ-018 ts_cnt (internal, TS_W bits) shall increment by 1 on every non-reset posedge, wrapping from all-ones to 0.
REQ-019 Each channel shall hold a filtered level filt[c] and a run counter; a sample din[c] != filt[c] increments the counter; a sample equal to filt[c] clears it.
REQ-020 When the counter for channel c reaches FILT_LEN, filt[c] shall toggle on that same posedge and the counter shall clear; this toggle is an edge (0->1 rising, 1->0 falling).
REQ-021 On the first posedge after reset deasserts (arm cycle), filt shall load din directly and no edge shall be reported.
REQ-022 An edge on channel c is reported only if mode[c] selects its polarity; mode is sampled on the posedge on which the toggle occurs.
REQ-023 All reported edges confirmed on the same posedge shall be merged into one entry {ts, edges, pol}; ts is the ts_cnt value before that posedge.
REQ-024 An entry shall be written on its confirming posedge; ev_valid for a previously empty FIFO rises on the next cycle (latency: FILT_LEN posedges from first differing sample to write).
REQ-025 The FIFO shall be first-word-fall-through; ev_ts/ev_edges/ev_pol hold the head entry while ev_valid is high and are 0 when empty.
REQ-026 Pop and push on the same posedge shall both take effect; fifo_level is unchanged.
REQ-027 A push when full and no pop on that posedge shall drop the entry, set overflow, and increment drop_cnt (saturating at 16'hFFFF).
REQ-028 A push when full with a simultaneous pop shall be accepted; no drop.
REQ-029 overflow_clr shall clear overflow and drop_cnt; a drop on the same posedge takes priority (overflow=1, drop_cnt=1).
REQ-030 Read and write pointers shall wrap modulo FIFO_DEPTH; ev_ready with ev_valid low has no effect.

Reset
REQ-031 While reset is high: ts_cnt=0, run counters=0, filt=0, FIFO emptied, ev_valid=0, ev_ts/ev_edges/ev_pol=0, fifo_level=0, overflow=0, drop_cnt=0; next posedge after deassert is the arm cycle.
REQ-032 Reset asserted mid-operation shall discard all pending entries and in-progress filter counts on that posedge.

Verification
REQ-033 FILT_LEN=2, mode=01 all: after reset and arm, din[0] 0->1 held -> one entry, ev_edges=0001, ev_pol=0001, ts = ts_cnt before the 2nd high sample.
REQ-034 FILT_LEN=2: din[1] pulses high for 1 cycle -> no entry; pulse held 2 cycles with mode=11 -> rising entry then falling entry.
REQ-035 din[0] and din[2] rise on same cycle, mode=11 -> single entry, ev_edges=0101, ev_pol=0101; din[3] falls with mode[3]=01 -> no entry.
REQ-036 ev_ready=0, generate FIFO_DEPTH+3 events -> fifo_level=FIFO_DEPTH, overflow=1, drop_cnt=3; overflow_clr -> both 0.
REQ-037 FIFO full, ev_ready=1 on an edge-confirm cycle -> entry accepted, drop_cnt unchanged, order preserved across pointer wrap.
REQ-038 din held high through reset -> arm cycle loads filt=1, no rising entry; reset pulse with 5 entries queued -> ev_valid=0, fifo_level=0 next cycle.
